maxpool_relu_1: RTL and testbench

- Consumer of the first convolution layer's output stream: takes three 12-bit signed channel results per valid cycle, in raster order over a 24x24 feature map.
- Applies 2x2 max pooling with stride 2 and ReLU per channel.
- Emits a 12x12 pooled map per channel to the next conv stage.
- Streaming, no backpressure; tolerates gaps in valid_in.

---
 rtl/cnn_pool_pkg.sv | 20 ++
 rtl/maxpool_relu_1_if.sv | 25 ++
 rtl/pool_lane.sv | 61 ++++++
 rtl/maxpool_relu_1.sv | 97 +++++++++
 tb/tb_maxpool_relu_1.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/cnn_pool_pkg.sv
// Shared types and arithmetic helpers for the pooling stage after conv layer 1.
// Latency: combinational helpers only.
// Backpressure: none; pure functions with no flow control.
package cnn_pool_pkg;

    localparam int DATA_BITS = 12;

    typedef logic signed [DATA_BITS-1:0] sample_t;

    // Signed maximum; on a tie both operands are equal, so either may be returned.
    function automatic sample_t smax(input sample_t a, input sample_t b);
        return (a > b) ? a : b;
    endfunction

    // Clamp negative values to zero.
    function automatic sample_t relu(input sample_t x);
        return (x < 0) ? sample_t'(0) : x;
    endfunction

endpackage

// File: rtl/maxpool_relu_1_if.sv
// Stream bundle between conv layer 1, the pooling stage and the next conv stage.
// Latency: wires only.
// Backpressure: none; valid-only in both directions.
interface maxpool_relu_1_if;
    import cnn_pool_pkg::*;

    logic    valid_in;
    sample_t conv_out_1;
    sample_t conv_out_2;
    sample_t conv_out_3;
    sample_t max_value_1;
    sample_t max_value_2;
    sample_t max_value_3;
    logic    valid_out_relu;

    modport master (
        output valid_in, conv_out_1, conv_out_2, conv_out_3,
        input  max_value_1, max_value_2, max_value_3, valid_out_relu
    );

    modport slave (
        input  valid_in, conv_out_1, conv_out_2, conv_out_3,
        output max_value_1, max_value_2, max_value_3, valid_out_relu
    );
endinterface

// File: rtl/pool_lane.sv
// One channel of 2x2/stride-2 max pooling with optional ReLU (macro MAXPOOL_RELU_RELU_EN).
// Latency: result registered on the edge that accepts the bottom-right sample of a window.
// Backpressure: none; the enables from the top freeze all state on idle cycles.
module pool_lane
    import cnn_pool_pkg::*;
#(
    parameter int LB_DEPTH = 12,
    parameter int IW       = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          pair_we,
    input  logic          lb_we,
    input  logic          emit,
    input  logic [IW-1:0] lb_idx,
    input  sample_t       sample_in,
    output sample_t       max_out
);

    sample_t pair_q, pair_d;
    sample_t max_q, max_d;
    sample_t lb_q [LB_DEPTH];
    sample_t pair_max;
    sample_t win_max;
    sample_t res;

    // Horizontal pair max, vertical merge with the line buffer, optional clamp.
    always_comb begin
        pair_d   = pair_we ? sample_in : pair_q;
        pair_max = smax(pair_q, sample_in);
        win_max  = smax(pair_max, lb_q[lb_idx]);
`ifdef MAXPOOL_RELU_RELU_EN
        res      = relu(win_max);
`else
        res      = win_max;
`endif
        max_d    = emit ? res : max_q;
    end

    // Pair register and output register; output holds between windows.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pair_q <= '0;
            max_q  <= '0;
        end else begin
            pair_q <= pair_d;
            max_q  <= max_d;
        end
    end

    // Line buffer of top-row pair maxima; every entry is written on an even row
    // before the odd row reads it, so it needs no reset.
    always_ff @(posedge clk) begin
        if (lb_we) begin
            lb_q[lb_idx] <= pair_max;
        end
    end

    assign max_out = max_q;

endmodule

// File: rtl/maxpool_relu_1.sv
// 2x2/stride-2 max pool + ReLU (macro MAXPOOL_RELU_RELU_EN) on three conv-1 channels.
// Latency: one registered stage; valid_out_relu pulses right after the accepting edge.
// Backpressure: none; valid_in gaps freeze counters and lane state.
module maxpool_relu_1
#(
    parameter int WIDTH     = 24,
    parameter int HEIGHT    = 24,
    parameter int DATA_BITS = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    maxpool_relu_1_if.slave  bus
);
    import cnn_pool_pkg::*;

    localparam int CW = $clog2(WIDTH);
    localparam int RW = $clog2(HEIGHT);
    localparam int IW = CW - 1;

    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic          vout_q, vout_d;
    logic          pair_we, lb_we, emit;
    logic [IW-1:0] lb_idx;
    logic [DATA_BITS-1:0] lane_max [3];

    // Raster position tracking and per-sample role decode shared by all lanes.
    always_comb begin
        pair_we = bus.valid_in & ~col_q[0];
        lb_we   = bus.valid_in &  col_q[0] & ~row_q[0];
        emit    = bus.valid_in &  col_q[0] &  row_q[0];
        lb_idx  = col_q[CW-1:1];
        col_d   = col_q;
        row_d   = row_q;
        if (bus.valid_in) begin
            if (col_q == CW'(WIDTH - 1)) begin
                col_d = '0;
                row_d = (row_q == RW'(HEIGHT - 1)) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
        vout_d = emit;
    end

    // Counters and output valid; reset discards any partial frame.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col_q  <= '0;
            row_q  <= '0;
            vout_q <= 1'b0;
        end else begin
            col_q  <= col_d;
            row_q  <= row_d;
            vout_q <= vout_d;
        end
    end

    pool_lane #(.LB_DEPTH(WIDTH / 2), .IW(IW)) u_lane_1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .pair_we   (pair_we),
        .lb_we     (lb_we),
        .emit      (emit),
        .lb_idx    (lb_idx),
        .sample_in (bus.conv_out_1),
        .max_out   (lane_max[0])
    );

    pool_lane #(.LB_DEPTH(WIDTH / 2), .IW(IW)) u_lane_2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .pair_we   (pair_we),
        .lb_we     (lb_we),
        .emit      (emit),
        .lb_idx    (lb_idx),
        .sample_in (bus.conv_out_2),
        .max_out   (lane_max[1])
    );

    pool_lane #(.LB_DEPTH(WIDTH / 2), .IW(IW)) u_lane_3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .pair_we   (pair_we),
        .lb_we     (lb_we),
        .emit      (emit),
        .lb_idx    (lb_idx),
        .sample_in (bus.conv_out_3),
        .max_out   (lane_max[2])
    );

    assign bus.max_value_1    = lane_max[0];
    assign bus.max_value_2    = lane_max[1];
    assign bus.max_value_3    = lane_max[2];
    assign bus.valid_out_relu = vout_q;

endmodule

// File: tb/tb_maxpool_relu_1.sv
// Scoreboard bench for maxpool_relu_1: a frame-image model predicts each pooled result.
// Latency: each expected entry carries the cycle its pulse must appear on.
// Backpressure: none; the bench inserts random valid_in gaps.
module tb_maxpool_relu_1;
    import cnn_pool_pkg::*;

    localparam int W = 24;
    localparam int H = 24;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    maxpool_relu_1_if bus();

    maxpool_relu_1 #(.WIDTH(W), .HEIGHT(H), .DATA_BITS(DATA_BITS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        sample_t e1;
        sample_t e2;
        sample_t e3;
        int      at;
    } exp_t;

    int      n_chk  = 0;
    int      n_pass = 0;
    int      cyc    = 0;
    int      pulses = 0;
    bit      mon_en = 1'b0;
    int      r_c    = 0;
    int      c_c    = 0;
    exp_t    sb[$];
    sample_t img [3][H][W];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Direct 2x2 window max over the stored image, then optional clamp.
    function automatic sample_t model(input int ch, input int r, input int c);
        int m;
        int v;
        m = img[ch][r-1][c-1];
        v = img[ch][r-1][c];  if (v > m) m = v;
        v = img[ch][r][c-1];  if (v > m) m = v;
        v = img[ch][r][c];    if (v > m) m = v;
`ifdef MAXPOOL_RELU_RELU_EN
        if (m < 0) m = 0;
`endif
        return sample_t'(m);
    endfunction

    function automatic sample_t rnd();
        return sample_t'($urandom_range(0, 4095));
    endfunction

    task automatic idle_cycle();
        @(posedge clk); #1;
        bus.valid_in   = 1'b0;
        bus.conv_out_1 = rnd();
        bus.conv_out_2 = rnd();
        bus.conv_out_3 = rnd();
    endtask

    task automatic put(input sample_t s1, input sample_t s2, input sample_t s3, input bit gaps);
        if (gaps) begin
            for (int g = 0; g < 4; g++) begin
                if ($urandom_range(0, 1) == 0) break;
                idle_cycle();
            end
        end
        @(posedge clk); #1;
        bus.valid_in   = 1'b1;
        bus.conv_out_1 = s1;
        bus.conv_out_2 = s2;
        bus.conv_out_3 = s3;
        img[0][r_c][c_c] = s1;
        img[1][r_c][c_c] = s2;
        img[2][r_c][c_c] = s3;
        if ((r_c % 2 == 1) && (c_c % 2 == 1))
            sb.push_back('{model(0, r_c, c_c), model(1, r_c, c_c), model(2, r_c, c_c), cyc + 1});
        if (c_c == W - 1) begin
            c_c = 0;
            r_c = (r_c == H - 1) ? 0 : r_c + 1;
        end else begin
            c_c = c_c + 1;
        end
    endtask

    function automatic sample_t mixed(input int r, input int c);
        if (r == 0 && c == 0) return sample_t'(-100);
        if (r == 0 && c == 1) return sample_t'(7);
        if (r == 1 && c == 0) return sample_t'(300);
        if (r == 1 && c == 1) return sample_t'(-2047);
        if (r == 0 && c == 2) return sample_t'(-1);
        if (r == 0 && c == 3) return sample_t'(-2);
        if (r == 1 && c == 2) return sample_t'(-3);
        if (r == 1 && c == 3) return sample_t'(-4);
        return rnd();
    endfunction

    // mode 0: ramp / constant -5 / mixed windows; mode 1: random on all channels
    task automatic frame(input int mode, input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (mode == 0) put(sample_t'(r_c * W + c_c), sample_t'(-5), mixed(r_c, c_c), gaps);
            else           put(rnd(), rnd(), rnd(), gaps);
        end
        idle_cycle();
        idle_cycle();
        @(negedge clk);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_v1"},  bus.max_value_1, 0);
        check({tag, "_v2"},  bus.max_value_2, 0);
        check({tag, "_v3"},  bus.max_value_3, 0);
        check({tag, "_vld"}, bus.valid_out_relu, 0);
    endtask

    task automatic do_reset(input int n);
        idle_cycle();
        @(negedge clk); #1;
        check("sb_empty_before_reset", sb.size(), 0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        for (int i = 0; i < n; i++) begin
            bus.valid_in   = 1'b1;
            bus.conv_out_1 = rnd();
            bus.conv_out_2 = rnd();
            bus.conv_out_3 = rnd();
            @(posedge clk); #1;
        end
        check_reset_state("rst_mid");
        rst_n        = 1'b1;
        bus.valid_in = 1'b0;
        r_c = 0;
        c_c = 0;
        sb.delete();
    endtask

    // Output monitor: quiet during reset, every pulse matches the scoreboard head.
    always @(negedge clk) begin : mon
        exp_t e;
        if (mon_en) begin
            if (!rst_n) begin
                check("quiet_in_reset", bus.valid_out_relu, 0);
            end else if (bus.valid_out_relu) begin
                pulses++;
                if (sb.size() == 0) begin
                    check("spurious_pulse", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("ch1", bus.max_value_1, e.e1);
                    check("ch2", bus.max_value_2, e.e2);
                    check("ch3", bus.max_value_3, e.e3);
                    check("latency", cyc, e.at);
                end
            end
        end
    end

    initial begin : main
        int p0;
        bus.valid_in   = 1'b0;
        bus.conv_out_1 = '0;
        bus.conv_out_2 = '0;
        bus.conv_out_3 = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("rst_init");
        rst_n  = 1'b1;
        mon_en = 1'b1;

        p0 = pulses;
        frame(0, W * H, 1'b0);
        check("ramp_pulses", pulses - p0, 144);
        check("ramp_last_v1", bus.max_value_1, 575);
        check("ramp_idle_vld", bus.valid_out_relu, 0);

        p0 = pulses;
        frame(0, W * H, 1'b1);
        check("gap_pulses", pulses - p0, 144);
        check("gap_last_v1", bus.max_value_1, 575);

        frame(1, 300, 1'b1);
        do_reset(3);
        p0 = pulses;
        frame(1, W * H, 1'b1);
        check("post_reset_pulses", pulses - p0, 144);

        p0 = pulses;
        frame(1, 2 * W * H, 1'b0);
        check("two_frame_pulses", pulses - p0, 288);

        idle_cycle();
        @(negedge clk);
        check("sb_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
